// File: rtl/vec_regfile_grp.sv
// Vector register file with LMUL-grouped reads, a one-register-per-cycle group write
// sequencer and a dedicated v0 mask port. Define VRF_WRITE_BYPASS_EN for read write-through.
module vec_regfile_grp #(
  parameter int VLEN       = 512,
  parameter int NUM_REGS   = 32,
  parameter int MAX_LMUL   = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [3:0]                 lmul,
  input  logic [ADDR_WIDTH-1:0]      raddr_1,
  input  logic [ADDR_WIDTH-1:0]      raddr_2,
  input  logic [ADDR_WIDTH-1:0]      raddr_3,
  output logic [VLEN*MAX_LMUL-1:0]   rdata_1,
  output logic [VLEN*MAX_LMUL-1:0]   rdata_2,
  output logic [VLEN*MAX_LMUL-1:0]   rdata_3,
  output logic [2:0]                 rd_err,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [ADDR_WIDTH-1:0]      waddr,
  input  logic [VLEN*MAX_LMUL-1:0]   wdata,
  output logic                       wr_busy,
  output logic                       wr_done,
  output logic                       wr_err,
  input  logic                       mask_wr_en,
  input  logic [VLEN-1:0]            mask_wdata,
  output logic [VLEN-1:0]            v0_mask_data
);

  localparam int GW = VLEN * MAX_LMUL;
  localparam int CW = (MAX_LMUL > 1) ? $clog2(MAX_LMUL) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_e;

  state_e                          state_q, state_d;
  logic [NUM_REGS-1:0][VLEN-1:0]   regs_q, regs_d;
  logic [ADDR_WIDTH-1:0]           base_q, base_d;
  logic [3:0]                      lmul_q, lmul_d;
  logic [GW-1:0]                   wdata_q, wdata_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic                            wr_err_q, wr_err_d;

  logic                            mask_we, accept, last_beat;
  logic [ADDR_WIDTH-1:0]           beat_addr;
  logic [NUM_REGS-1:0][VLEN-1:0]   view;

  function automatic logic grp_legal(input logic [ADDR_WIDTH-1:0] a, input logic [3:0] l);
    logic [31:0] ai, li;
    ai = 32'(a);
    li = 32'(l);
    return (l == 4'd1 || l == 4'd2 || l == 4'd4 || l == 4'd8) &&
           (li <= 32'(MAX_LMUL)) && ((ai & (li - 32'd1)) == 32'd0) &&
           ((ai + li) <= 32'(NUM_REGS));
  endfunction

  // Mask write wins over a new group request, hence wr_ready drops with mask_wr_en.
  assign mask_we   = mask_wr_en && (state_q != S_WRITE);
  assign wr_ready  = (state_q != S_WRITE) && !mask_wr_en;
  assign wr_busy   = (state_q == S_WRITE);
  assign wr_done   = (state_q == S_DONE);
  assign wr_err    = wr_err_q;
  assign accept    = wr_valid && wr_ready;
  assign beat_addr = base_q + ADDR_WIDTH'(cnt_q);
  assign last_beat = (32'(cnt_q) + 32'd1) == 32'(lmul_q);

  always_comb begin
    state_d  = state_q;
    regs_d   = regs_q;
    base_d   = base_q;
    lmul_d   = lmul_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    wr_err_d = 1'b0;
    case (state_q)
      S_WRITE: begin
        regs_d[beat_addr] = wdata_q[cnt_q*VLEN +: VLEN];
        cnt_d             = cnt_q + CW'(1);
        if (last_beat) state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          if (grp_legal(waddr, lmul)) begin
            base_d  = waddr;
            lmul_d  = lmul;
            wdata_d = wdata;
            cnt_d   = '0;
            state_d = S_WRITE;
          end else begin
            wr_err_d = 1'b1;
          end
        end
      end
    endcase
    if (mask_we) regs_d[0] = mask_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      regs_q   <= '0;
      base_q   <= '0;
      lmul_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      regs_q   <= regs_d;
      base_q   <= base_d;
      lmul_q   <= lmul_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      wr_err_q <= wr_err_d;
    end
  end

  // regs_d already carries this cycle's beat and mask write, so it is the write-through view.
`ifdef VRF_WRITE_BYPASS_EN
  assign view = regs_d;
`else
  assign view = regs_q;
`endif

  assign v0_mask_data = view[0];

  logic [2:0][ADDR_WIDTH-1:0] ra;
  logic [2:0][GW-1:0]         rd;
  logic [2:0]                 rlegal;

  assign ra = {raddr_3, raddr_2, raddr_1};

  for (genvar p = 0; p < 3; p++) begin : g_port
    assign rlegal[p] = grp_legal(ra[p], lmul);
    for (genvar k = 0; k < MAX_LMUL; k++) begin : g_slice
      logic [ADDR_WIDTH-1:0] idx;
      assign idx = ra[p] + ADDR_WIDTH'(k);
      assign rd[p][k*VLEN +: VLEN] = (rlegal[p] && (32'(lmul) > 32'(k))) ? view[idx] : '0;
    end
  end

  assign rdata_1 = rd[0];
  assign rdata_2 = rd[1];
  assign rdata_3 = rd[2];
  assign rd_err  = ~rlegal;

endmodule

// File: tb/tb_vec_regfile_grp.sv
// Scoreboard bench for vec_regfile_grp: stimulus queues expected values and pulses,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_vec_regfile_grp;
  localparam int VLEN = 512, NUM_REGS = 32, MAX_LMUL = 8, AW = 5;
  localparam int GW = VLEN * MAX_LMUL;

  logic           clk = 1'b0;
  logic           reset;
  logic [3:0]     lmul;
  logic [AW-1:0]  raddr_1, raddr_2, raddr_3, waddr;
  logic [GW-1:0]  rdata_1, rdata_2, rdata_3, wdata;
  logic [2:0]     rd_err;
  logic           wr_valid, wr_ready, wr_busy, wr_done, wr_err, mask_wr_en;
  logic [VLEN-1:0] mask_wdata, v0_mask_data;

  vec_regfile_grp #(.VLEN(VLEN), .NUM_REGS(NUM_REGS), .MAX_LMUL(MAX_LMUL), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .lmul(lmul),
    .raddr_1(raddr_1), .raddr_2(raddr_2), .raddr_3(raddr_3),
    .rdata_1(rdata_1), .rdata_2(rdata_2), .rdata_3(rdata_3), .rd_err(rd_err),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .waddr(waddr), .wdata(wdata),
    .wr_busy(wr_busy), .wr_done(wr_done), .wr_err(wr_err),
    .mask_wr_en(mask_wr_en), .mask_wdata(mask_wdata), .v0_mask_data(v0_mask_data));

  always #5 clk = ~clk;

  typedef enum int {S_RD1, S_RD2, S_RD3, S_RDERR, S_RDY, S_BUSY, S_V0} sel_e;
  typedef struct { sel_e sel; string name; logic [GW-1:0] exp; } chk_t;
  typedef struct { bit is_done; int cyc; } pulse_t;

  chk_t   chk_q[$];
  pulse_t pulse_q[$];
  int     cyc = 0;
  int     nvec = 0, nerr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [GW-1:0] pick(input sel_e s);
    case (s)
      S_RD1:   return rdata_1;
      S_RD2:   return rdata_2;
      S_RD3:   return rdata_3;
      S_RDERR: return GW'(rd_err);
      S_RDY:   return GW'(wr_ready);
      S_BUSY:  return GW'(wr_busy);
      default: return GW'(v0_mask_data);
    endcase
  endfunction

  // Monitor: drain queued checks each negedge and match every done/err pulse.
  always @(negedge clk) begin
    while (chk_q.size() > 0) begin
      chk_t c;
      logic [GW-1:0] got;
      c   = chk_q.pop_front();
      got = pick(c.sel);
      nvec++;
      if (got !== c.exp) begin
        int w = 0;
        for (int i = GW/32 - 1; i >= 0; i--)
          if (got[i*32 +: 32] !== c.exp[i*32 +: 32]) w = i;
        nerr++;
        $display("FAIL %s: word %0d got %h want %h", c.name, w, got[w*32 +: 32], c.exp[w*32 +: 32]);
      end
    end
    if (wr_done === 1'b1 || wr_err === 1'b1) begin
      nvec++;
      if (pulse_q.size() == 0) begin
        nerr++;
        $display("FAIL pulse: unexpected done=%b err=%b at cycle %0d, want none", wr_done, wr_err, cyc);
      end else begin
        pulse_t p;
        p = pulse_q.pop_front();
        if (wr_done !== p.is_done || wr_err !== !p.is_done || cyc != p.cyc) begin
          nerr++;
          $display("FAIL pulse: got done=%b err=%b cycle %0d, want done=%0d cycle %0d",
                   wr_done, wr_err, cyc, p.is_done, p.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input sel_e s, input string n, input logic [GW-1:0] e);
    chk_t c;
    c.sel = s; c.name = n; c.exp = e;
    chk_q.push_back(c);
  endtask

  task automatic exp_pulse(input bit d, input int at);
    pulse_t p;
    p.is_done = d; p.cyc = at;
    pulse_q.push_back(p);
  endtask

  function automatic logic [GW-1:0] grp(input logic [VLEN-1:0] s0, s1, s2, s3);
    logic [GW-1:0] v;
    v = '0;
    v[0*VLEN +: VLEN] = s0;
    v[1*VLEN +: VLEN] = s1;
    v[2*VLEN +: VLEN] = s2;
    v[3*VLEN +: VLEN] = s3;
    return v;
  endfunction

  logic [GW-1:0] g8;

  initial begin
    reset = 1'b0; lmul = 4'd1; raddr_1 = '0; raddr_2 = '0; raddr_3 = '0;
    waddr = '0; wdata = '0; wr_valid = 1'b0; mask_wr_en = 1'b0; mask_wdata = '0;
    #1;
    chk(S_RDY, "rst_ready", GW'(1));
    chk(S_BUSY, "rst_busy", '0);
    tick(); tick();
    reset = 1'b1;

    // Reset state with lmul=1
    chk(S_RD1, "init_rd1", '0); chk(S_RD2, "init_rd2", '0); chk(S_RD3, "init_rd3", '0);
    chk(S_RDY, "init_ready", GW'(1)); chk(S_V0, "init_v0", '0); chk(S_RDERR, "init_rderr", '0);
    tick();

    // lmul=4 group write to v8..v11; inputs scrambled while the sequencer runs
    g8 = grp('h11, 'h22, 'h33, 'h44);
    lmul = 4'd4; waddr = 5'd8; wdata = g8; wr_valid = 1'b1;
    exp_pulse(1'b1, cyc + 1 + 4);
    tick();
    wr_valid = 1'b0; waddr = 5'd16; wdata = '1; lmul = 4'd2;
    for (int i = 0; i < 4; i++) begin
      chk(S_BUSY, "g4_busy", GW'(1));
      chk(S_RDY, "g4_notready", '0);
      tick();
    end
    lmul = 4'd4; raddr_3 = 5'd8; raddr_1 = 5'd16;
    chk(S_BUSY, "g4_idle", '0);
    chk(S_RD3, "g4_rd3", g8);
    chk(S_RD1, "g4_untouched", '0);
    tick();

    // Misaligned lmul=2 write is dropped with an error pulse
    lmul = 4'd2; waddr = 5'd3; wdata = '1; wr_valid = 1'b1;
    raddr_1 = 5'd3; raddr_2 = 5'd0; raddr_3 = 5'd8;
    exp_pulse(1'b0, cyc + 1);
    chk(S_RD1, "mis_rd1", '0);
    chk(S_RDERR, "mis_rderr", GW'(3'b001));
    chk(S_RD3, "mis_rd3", grp('h11, 'h22, '0, '0));
    tick();
    wr_valid = 1'b0;
    tick();
    lmul = 4'd4; raddr_2 = 5'd2; raddr_3 = 5'd8;
    chk(S_RD3, "mis_nochange", g8);
    chk(S_RD2, "lmul4_misalign", '0);
    chk(S_RDERR, "lmul4_rderr", GW'(3'b011));
    tick();

    // Mask write while idle, then ignored during a group write
    mask_wr_en = 1'b1; mask_wdata = 'hDEADBEEF;
    chk(S_RDY, "mask_prio", '0);
    tick();
    mask_wr_en = 1'b0; lmul = 4'd1; raddr_1 = 5'd0;
    chk(S_V0, "mask_v0", VLEN'('hDEADBEEF));
    chk(S_RD1, "mask_rd1", GW'(VLEN'('hDEADBEEF)));
    lmul = 4'd2; raddr_1 = 5'd0;
    chk(S_RD1, "mask_rd1_g2", GW'(VLEN'('hDEADBEEF)));
    waddr = 5'd2; wdata = grp('hAAAA, 'hBBBB, '0, '0); wr_valid = 1'b1;
    exp_pulse(1'b1, cyc + 1 + 2);
    tick();
    wr_valid = 1'b0; mask_wr_en = 1'b1; mask_wdata = 'h12345678;
    chk(S_BUSY, "mw_busy", GW'(1));
    tick();
    mask_wr_en = 1'b0;
    tick();
    raddr_1 = 5'd2;
    chk(S_V0, "mask_ignored", VLEN'('hDEADBEEF));
    chk(S_RD1, "mw_grp", grp('hAAAA, 'hBBBB, '0, '0));
    tick();

    // Back-to-back lmul=1 writes, second accepted in the DONE cycle
    lmul = 4'd1; waddr = 5'd5; wdata = GW'('h55); wr_valid = 1'b1;
    exp_pulse(1'b1, cyc + 2);
    exp_pulse(1'b1, cyc + 4);
    tick();
    waddr = 5'd6; wdata = GW'('h66);
    tick();
    chk(S_RDY, "b2b_ready_done", GW'(1));
    tick();
    wr_valid = 1'b0;
    tick();
    raddr_1 = 5'd5; raddr_2 = 5'd6;
    chk(S_RD1, "b2b_r5", GW'('h55));
    chk(S_RD2, "b2b_r6", GW'('h66));
    tick();

    // lmul=8 write to v24..v31 abandoned by reset after three beats
    lmul = 4'd8; waddr = 5'd24; wr_valid = 1'b1;
    for (int k = 0; k < 8; k++) wdata[k*VLEN +: VLEN] = VLEN'(32'h100 + k);
    tick();
    wr_valid = 1'b0;
    tick(); tick(); tick();
    reset = 1'b0;
    raddr_1 = 5'd24; raddr_2 = 5'd0;
    chk(S_RDY, "rst_mid_ready", GW'(1));
    chk(S_BUSY, "rst_mid_busy", '0);
    chk(S_RD1, "rst_mid_rd", '0);
    chk(S_V0, "rst_mid_v0", '0);
    tick();
    reset = 1'b1;
    lmul = 4'd4; raddr_3 = 5'd8;
    chk(S_RD3, "post_rst_g8", '0);
    tick(); tick(); tick();

    nvec++;
    if (pulse_q.size() != 0) begin
      nerr++;
      $display("FAIL pulses_left: got %0d pending, want 0", pulse_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
